// File: rtl/hazard_scoreboard.sv
// Register scoreboard and issue controller between decode and execute.
// Counts outstanding writes per register, gates issue on hazards, and offers a drain handshake.
module hazard_scoreboard #(
  parameter int W_RD  = 4,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 v_i,
  input  logic [W_RD-1:0]      rs0_i,
  input  logic                 rs0_use_i,
  input  logic [W_RD-1:0]      rs1_i,
  input  logic                 rs1_use_i,
  input  logic [W_RD-1:0]      rd_i,
  input  logic                 rd_use_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 wb_i,
  input  logic [W_RD-1:0]      wb_r_i,
  input  logic                 drain_i,
  output logic                 issue_o,
  output logic                 stall_o,
  output logic [2**W_RD-1:0]   busy_o,
  output logic                 drain_done_o,
  output logic                 err_o
);

  localparam int N_REG = 2**W_RD;
  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [N_REG];
  logic [CNT_W-1:0] cnt_nxt [N_REG];
  logic [N_REG-1:0] inc_vec, dec_vec, busy_nxt;
  logic             err_set, all_idle_nxt, run_nxt;
  logic             rs0_rdy, rs1_rdy, rd_ok;
  logic             wb_rs0, wb_rs1, wb_rd;

  assign wb_rs0 = wb_i && (wb_r_i == rs0_i);
  assign wb_rs1 = wb_i && (wb_r_i == rs1_i);
  assign wb_rd  = wb_i && (wb_r_i == rd_i);

  // A last pending write retiring this cycle is forwarded by the register file.
  assign rs0_rdy = !rs0_use_i || (cnt[rs0_i] == '0) || ((cnt[rs0_i] == ONE) && wb_rs0);
  assign rs1_rdy = !rs1_use_i || (cnt[rs1_i] == '0) || ((cnt[rs1_i] == ONE) && wb_rs1);
  assign rd_ok   = !rd_use_i  || (cnt[rd_i] != MAXC) || wb_rd;

  // Issue is judged against the next FSM state; every state heads to RUN exactly when drain_i is low.
  assign run_nxt = !drain_i;
  assign issue_o = run_nxt && v_i && !stall_i && !flush_i && rs0_rdy && rs1_rdy && rd_ok;
  assign stall_o = v_i && !issue_o && !flush_i;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_o && rd_use_i) inc_vec[rd_i] = 1'b1;
    if (wb_i)                dec_vec[wb_r_i] = 1'b1;
  end

  always_comb begin
    err_set      = 1'b0;
    all_idle_nxt = 1'b1;
    busy_nxt     = '0;
    for (int r = 0; r < N_REG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_nxt[r] = (cnt[r] == MAXC) ? MAXC : cnt[r] + ONE;
      end else if (!inc_vec[r] && dec_vec[r]) begin
        if (cnt[r] == '0) err_set = 1'b1;
        else              cnt_nxt[r] = cnt[r] - ONE;
      end
      busy_nxt[r] = (cnt_nxt[r] != '0);
      if (cnt_nxt[r] != '0) all_idle_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (drain_i) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_i)          state_nxt = RUN;
        else if (all_idle_nxt) state_nxt = DONE;
      end
      DONE:    if (!drain_i) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      busy_o       <= '0;
      drain_done_o <= 1'b0;
      err_o        <= 1'b0;
      for (int r = 0; r < N_REG; r++) cnt[r] <= '0;
    end else begin
      state        <= state_nxt;
      busy_o       <= busy_nxt;
      drain_done_o <= (state_nxt == DONE);
      err_o        <= err_o | err_set;
      for (int r = 0; r < N_REG; r++) cnt[r] <= cnt_nxt[r];
    end
  end

endmodule
